multdiv_seq: RTL and testbench
==============================

MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Port clock, input, 1, single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port ctrl_MULT, input, 1, single-cycle request to start a signed multiply.
REQ-006 Port ctrl_DIV, input, 1, single-cycle request to start a signed divide.
REQ-007 Port data_operandA, input, WIDTH, multiplicand or dividend; sampled only on the accept edge.
REQ-008 Port data_operandB, input, WIDTH, multiplier or divisor; sampled only on the accept edge.
REQ-009 Port data_result, output, WIDTH, product low word or quotient; held until the next operation completes.
REQ-010 Port data_exception, output, 1, overflow or divide-by-zero flag; valid with data_resultRDY.
REQ-011 Port data_resultRDY, output, 1, one-cycle pulse marking the result valid.
REQ-012 Port stall, output, 1, asserted while busy so the processor holds its multdiv stage.

Function
REQ-013 FSM states SHALL be IDLE, MULT, DIV and DONE, encoded in a shared enumeration.
REQ-014 In IDLE, ctrl_MULT or ctrl_DIV SHALL be accepted on a rising edge, latching the operand magnitudes, the result sign and the operation.
REQ-015 If ctrl_MULT and ctrl_DIV are both high on the same edge, MULT SHALL win and DIV SHALL be dropped.
REQ-016 ctrl_MULT and ctrl_DIV SHALL be ignored in every state other than IDLE; no queueing.
REQ-017 MULT and DIV SHALL each iterate exactly WIDTH cycles, unsigned radix-2: shift-add for MULT, restoring shift-subtract for DIV, with the counter counting 0 to WIDTH-1.
REQ-018 After the last iteration the FSM SHALL enter DONE for one cycle, then return to IDLE.
REQ-019 data_resultRDY SHALL be high only in DONE; accept-to-RDY latency SHALL be WIDTH+1 cycles.
REQ-020 stall SHALL be high from the cycle after accept through the DONE cycle inclusive, and low in IDLE.
REQ-021 The result sign SHALL be the XOR of the operand signs; the quotient SHALL truncate toward zero.
REQ-022 MULT exception SHALL be set when the signed 2*WIDTH product does not fit in WIDTH signed bits.
REQ-023 A DIV with divisor 0 SHALL skip iteration and go directly to DONE on the next edge, with data_exception=1 and data_result=0; latency SHALL be 1 cycle.
REQ-024 The most-negative operand SHALL be handled through an unsigned WIDTH+1 magnitude: MIN/(-1) sets the exception, and MIN*1 = MIN with no exception.
REQ-025 data_result and data_exception SHALL update only on entry to DONE.

Reset
REQ-026 On reset assertion the FSM SHALL go to IDLE asynchronously, and the counter and working registers SHALL clear.
REQ-027 On reset, outputs SHALL be: data_result=0, data_exception=0, data_resultRDY=0, stall=0.
REQ-028 Reset mid-operation SHALL abandon the operation with no RDY pulse; a request on the first edge after deassertion SHALL be accepted.

Structure
REQ-029 Shared package multdiv_pkg SHALL hold the FSM state enumeration, WIDTH/CNT_W defaults and the op-select constants.
REQ-030 One sub-module multdiv_step SHALL implement the combinational single-iteration add/subtract-and-shift; the FSM, counter and sign handling SHALL stay in multdiv_seq.

Verification
REQ-031 Multiply: ctrl_MULT with A=7, B=6 -> RDY exactly 33 cycles later, result 42, exception 0, stall high for 33 cycles.
REQ-032 Signed ops: A=-7, B=6 MULT -> -42. A=-100, B=7 DIV -> -14. A=100, B=-7 DIV -> -14. No exception in any case.
REQ-033 Exceptions: A=65536, B=65536 MULT -> exception 1 at RDY. A=5, B=0 DIV -> RDY 1 cycle after accept, result 0, exception 1.
REQ-034 Request collisions: ctrl_MULT and ctrl_DIV together with A=12, B=3 -> result 36. A ctrl_DIV pulse at cycle 10 of a MULT -> ignored, single RDY.
REQ-035 Reset mid-op: reset at cycle 15 of a DIV -> immediate IDLE, all outputs 0, no RDY; a following MULT 3*3 -> result 9.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the sequential signed multiply/divide unit.
//   - WIDTH_DEF / CNT_W_DEF : default operand width and iteration counter width
//   - ST_*                  : FSM state encoding shared by every file of the unit
//   - OP_*                  : operation select latched at accept time
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;   // 2**CNT_W_DEF must exceed WIDTH_DEF

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: processor <-> multdiv request/result bundle.
//   master : processor side (drives ctrl_MULT/ctrl_DIV and operands, sees results)
//   slave  : multdiv_seq side
//   ctrl_MULT / ctrl_DIV : single-cycle start requests
//   data_operandA/B      : operands, sampled on the accept edge only
//   data_result          : product low word or quotient, held until next completion
//   data_exception       : overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY       : one-cycle result-valid pulse
//   stall                : busy, processor holds its multdiv stage
interface multdiv_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             stall;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, stall
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, stall
  );

endinterface

// File: rtl/multdiv_step.sv
// multdiv_step: one combinational radix-2 iteration on unsigned magnitudes.
//   op_i   : OP_MULT -> shift-add, OP_DIV -> restoring shift-subtract
//   hi_i   : product high word (MULT) or partial remainder (DIV)
//   lo_i   : multiplier/product low word (MULT) or dividend/quotient (DIV)
//   opnd_i : multiplicand (MULT) or divisor (DIV) magnitude
//   hi_o/lo_o : register values after this iteration
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             op_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // NOTE: every output and temporary gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    ge      = 1'b0;
    hi_o    = hi_i;
    lo_o    = lo_i;
    if (op_i == OP_MULT) begin
      // Add the multiplicand when the current multiplier bit is set, then
      // shift {carry, hi, lo} right; the product accumulates in {hi, lo}.
      sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end else begin
      // Shift the next dividend bit into the remainder; subtract only when it
      // does not go negative. The difference is below the divisor, so WIDTH
      // bits of the subtraction are exact.
      shifted = {hi_i, lo_i[WIDTH-1]};
      ge      = shifted >= {1'b0, opnd_i};
      diff    = shifted[WIDTH-1:0] - opnd_i;
      hi_o    = ge ? diff : shifted[WIDTH-1:0];
      lo_o    = {lo_i[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed multiply / divide, one bit per cycle.
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset
//   bus   : multdiv_if slave port (requests, operands, result, exception,
//           resultRDY pulse, stall)
// Operands are converted to unsigned magnitudes on accept, WIDTH iterations of
// multdiv_step run, and the sign (XOR of operand signs) is applied on entry to
// DONE. A divide by zero bypasses iteration and completes on the next edge.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic      clock,
  input  logic      reset,
  multdiv_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             mult_fits;

  // An unsigned WIDTH-bit magnitude holds 2**(WIDTH-1), so the most negative
  // operand needs no special case here.
  assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i   (op_q),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // The signed product fits when the high word is zero and the low word is
  // at most 2**(WIDTH-1)-1, or exactly 2**(WIDTH-1) for a negative result.
  assign mult_fits = (step_hi == '0) &&
                     (!step_lo[WIDTH-1] || (sign_q && step_lo[WIDTH-2:0] == '0));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
          // MULT has priority when both requests arrive together.
          sign_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          cnt_d  = '0;
          hi_d   = '0;
          if (bus.ctrl_MULT) begin
            op_d    = OP_MULT;
            lo_d    = mag_b;
            opnd_d  = mag_a;
            state_d = ST_MULT;
          end else begin
            op_d   = OP_DIV;
            lo_d   = mag_a;
            opnd_d = mag_b;
            if (bus.data_operandB == '0) begin
              result_d = '0;
              exc_d    = 1'b1;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
      end
      ST_MULT, ST_DIV: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d    = '0;
          state_d  = ST_DONE;
          result_d = sign_q ? -step_lo : step_lo;
          // Only |MIN| / 1 with a positive sign overflows a quotient.
          exc_d    = (state_q == ST_MULT) ? !mult_fits : (!sign_q && step_lo[WIDTH-1]);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others; all working registers clear on reset so
  // an abandoned operation leaves nothing behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == ST_DONE);
  assign bus.stall          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed self-checking bench for multdiv_seq (WIDTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multdiv_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int LAT   = WIDTH + 1;
  localparam int MAX_WAIT = 100;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  multdiv_if #(.WIDTH(WIDTH)) bus ();

  multdiv_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request on the current falling edge; returns on the falling
  // edge after the accept edge (cycle 1 of the operation).
  task automatic start_op(input logic mult, input logic div,
                          input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = mult;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  // Run one operation and check latency, stall length, result, exception and
  // the return to idle. lat reports -1 if no RDY arrives within MAX_WAIT.
  task automatic run_op(input string tag, input logic mult, input logic div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic chk_res, input logic [31:0] exp_res,
                        input logic exp_exc, input int exp_lat);
    int lat;
    int stall_cycles;
    logic [31:0] res;
    logic exc;
    lat = -1;
    stall_cycles = 0;
    res = '0;
    exc = 1'b0;
    start_op(mult, div, a, b);
    for (int n = 1; n <= MAX_WAIT; n++) begin
      if (bus.stall) stall_cycles++;
      if (bus.data_resultRDY) begin
        lat = n;
        res = bus.data_result;
        exc = bus.data_exception;
        break;
      end
      @(negedge clock);
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " stall_cycles"}, stall_cycles, exp_lat);
    if (chk_res) check({tag, " result"}, res, exp_res);
    check({tag, " exception"}, {31'd0, exc}, {31'd0, exp_exc});
    @(negedge clock);
    check({tag, " idle_rdy"}, {31'd0, bus.data_resultRDY}, 32'd0);
    check({tag, " idle_stall"}, {31'd0, bus.stall}, 32'd0);
    check({tag, " held_result"}, bus.data_result, res);
  endtask

  initial begin
    int rdy_cnt;
    int first_rdy;
    logic [31:0] res;

    checks = 0;
    errors = 0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    reset = 1'b1;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst result", bus.data_result, 32'd0);
    check("rst exception", {31'd0, bus.data_exception}, 32'd0);
    check("rst rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    check("rst stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic and signed operations
    run_op("mul 7*6",      1'b1, 1'b0, 32'd7,     32'd6,  1'b1, 32'd42,  1'b0, LAT);
    run_op("mul -7*6",     1'b1, 1'b0, -32'sd7,   32'd6,  1'b1, -32'sd42, 1'b0, LAT);
    run_op("div -100/7",   1'b0, 1'b1, -32'sd100, 32'd7,  1'b1, -32'sd14, 1'b0, LAT);
    run_op("div 100/-7",   1'b0, 1'b1, 32'd100,  -32'sd7, 1'b1, -32'sd14, 1'b0, LAT);
    run_op("div 100/7",    1'b0, 1'b1, 32'd100,   32'd7,  1'b1, 32'd14,  1'b0, LAT);

    // Exceptions and most-negative operand
    run_op("mul ovf",      1'b1, 1'b0, 32'd65536, 32'd65536, 1'b1, 32'd0, 1'b1, LAT);
    run_op("div by zero",  1'b0, 1'b1, 32'd5,     32'd0,  1'b1, 32'd0,   1'b1, 1);
    run_op("mul MIN*1",    1'b1, 1'b0, 32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b0, LAT);
    run_op("mul MIN*-1",   1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, LAT);
    run_op("div MIN/-1",   1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, LAT);

    // Simultaneous requests: MULT wins (12*3=36, not 12/3=4)
    run_op("both req",     1'b1, 1'b1, 32'd12,    32'd3,  1'b1, 32'd36,  1'b0, LAT);

    // DIV pulse during cycle 10 of a MULT is ignored
    rdy_cnt = 0;
    first_rdy = -1;
    res = '0;
    start_op(1'b1, 1'b0, 32'd5, 32'd4);
    for (int n = 1; n <= 60; n++) begin
      bus.ctrl_DIV      = (n == 10);
      bus.data_operandB = (n == 10) ? 32'd0 : 32'd4;
      if (bus.data_resultRDY) begin
        rdy_cnt++;
        if (first_rdy < 0) begin
          first_rdy = n;
          res = bus.data_result;
        end
      end
      @(negedge clock);
    end
    bus.ctrl_DIV = 1'b0;
    check("ignored div rdy_count", rdy_cnt, 1);
    check("ignored div latency", first_rdy, LAT);
    check("ignored div result", res, 32'd20);

    // Reset in cycle 15 of a DIV, then a MULT on the first edge after release
    start_op(1'b0, 1'b1, -32'sd100, 32'd7);
    repeat (14) @(negedge clock);
    check("mid-op stall", {31'd0, bus.stall}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async rst result", bus.data_result, 32'd0);
    check("async rst exception", {31'd0, bus.data_exception}, 32'd0);
    check("async rst rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    check("async rst stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clock);
    check("held rst stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b0;
    run_op("post-rst 3*3", 1'b1, 1'b0, 32'd3, 32'd3, 1'b1, 32'd9, 1'b0, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
